// File: rtl/rom_pkg.sv
// rom_pkg: shared widths, FSM states and buffered word type for the ROM burst reader.
package rom_pkg;
  localparam int WIDTH  = 32;
  localparam int DEPTH  = 8;
  localparam int LEN_W  = 9;
  localparam int RD_LAT = 1;
  typedef enum logic [1:0] {IDLE, READ, DRAIN} rd_state_e;
  typedef logic [WIDTH:0] rd_word_t;
endpackage

// File: rtl/rom_rd_fifo.sv
// rom_rd_fifo: 2-entry FIFO holding captured ROM words with their last-beat flag.
module rom_rd_fifo
  import rom_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_wr,
  input  rd_word_t   i_din,
  input  logic       i_rd,
  output rd_word_t   o_dout,
  output logic [1:0] o_count
);
  rd_word_t   r_mem [2];
  logic       r_wp, r_rp;
  logic [1:0] r_count;
  assign o_dout  = r_mem[r_rp];
  assign o_count = r_count;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_wr) begin
        r_mem[r_wp] <= i_din;
        r_wp        <= !r_wp;
      end
      if (i_rd) r_rp <= !r_rp;
      r_count <= r_count + {1'b0, i_wr} - {1'b0, i_rd};
    end
  end
endmodule

// File: rtl/rom_burst_reader.sv
// rom_burst_reader: issues ROM reads for a burst and streams the words out as valid/ready with last.
module rom_burst_reader
  import rom_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DEPTH-1:0] base_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [DEPTH-1:0] rom_addr,
  output logic             rom_re,
  input  logic [WIDTH-1:0] rom_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);
  rd_state_e         r_state, w_next;
  logic [DEPTH-1:0]  r_addr, r_last_addr;
  logic [LEN_W-1:0]  r_rem;
  logic [RD_LAT-1:0] r_pv, r_pl;
  logic              r_done, w_done, w_issue, w_pop, w_accept;
  logic [1:0]        w_count;
  rd_word_t          w_head;
  assign w_accept = r_state == IDLE && start;
  assign w_pop    = out_valid && out_ready;
  // a word leaving the buffer this cycle frees its slot for a new issue
  assign w_issue  = r_state == READ && (int'(w_count) + $countones(r_pv) - int'(w_pop) < 2);
  assign rom_re   = w_issue;
  assign rom_addr = w_issue ? r_addr : r_last_addr;
  assign busy     = r_state != IDLE;
  assign done     = r_done;
  assign out_valid = w_count != 2'd0;
  assign {out_last, out_data} = w_head;
  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    if (w_accept) begin
      w_next = len != '0 ? READ : IDLE;
      w_done = len == '0;
    end
    if (r_state == READ && w_issue && r_rem == LEN_W'(1)) w_next = DRAIN;
    if (r_state == DRAIN && r_pv == '0 && w_count == 2'd0) begin
      w_next = IDLE;
      w_done = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_done;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_last_addr <= '0;
      r_rem       <= '0;
    end else if (w_accept) begin
      r_addr <= base_addr;
      r_rem  <= len;
    end else if (w_issue) begin
      r_addr      <= r_addr + DEPTH'(1);
      r_last_addr <= r_addr;
      r_rem       <= r_rem - LEN_W'(1);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pv <= '0;
      r_pl <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        r_pv[i] <= r_pv[i-1];
        r_pl[i] <= r_pl[i-1];
      end
      r_pv[0] <= w_issue;
      r_pl[0] <= w_issue && r_rem == LEN_W'(1);
    end
  end
  rom_rd_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_wr    (r_pv[RD_LAT-1]),
    .i_din   ({r_pl[RD_LAT-1], rom_data}),
    .i_rd    (w_pop),
    .o_dout  (w_head),
    .o_count (w_count)
  );
endmodule

// File: tb/tb_rom_burst_reader.sv
// tb_rom_burst_reader: ROM model plus burst reader, checked against a word-queue reference.
module tb_rom_burst_reader;
  import rom_pkg::*;
  logic             clk = 1'b0, rst = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic [DEPTH-1:0] base_addr = '0, rom_addr;
  logic [LEN_W-1:0] len = '0;
  logic             busy, done, rom_re, out_valid, out_last;
  logic [WIDTH-1:0] rom_data = '0, out_data;
  logic [WIDTH-1:0] rom_mem [256];
  logic [WIDTH:0]   exp_q [$];
  int               n_cmp = 0, n_fail = 0;
  int               occ = 0, infl = 0, n_iss = 0, n_done = 0, bc = 0, mode = 0;
  int               first_v = -1, first_pop = -1, last_pop = -1;
  logic             held = 1'b0, held_last = 1'b0;
  logic [WIDTH-1:0] held_data = '0;
  logic [DEPTH-1:0] exp_addr = '0;

  always #5 clk = ~clk;
  always @(posedge clk) if (rom_re) rom_data <= rom_mem[rom_addr];

  rom_burst_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .rom_addr(rom_addr), .rom_re(rom_re), .rom_data(rom_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy_for(input int m, input int c);
    if (m == 0) return 1'b1;
    if (m == 1) return c < 10 ? (c % 2 == 0) : (c >= 15);
    return $urandom_range(0, 3) != 0;
  endfunction

  // one cycle: drive inputs just after the edge, then sample and score the settled outputs
  task automatic step();
    logic           pop;
    logic [WIDTH:0] w;
    @(posedge clk); #1;
    start     = 1'b0;
    out_ready = rdy_for(mode, bc);
    #1;
    bc++;
    pop = out_valid && out_ready;
    chk("valid_vs_model", out_valid, occ != 0);
    if (held) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, held_data);
      chk("stall_last", out_last, held_last);
    end
    if (out_valid && first_v < 0) first_v = bc;
    if (pop) begin
      chk("word_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk("data", out_data, w[WIDTH-1:0]);
        chk("last", out_last, w[WIDTH]);
      end
      if (first_pop < 0) first_pop = bc;
      last_pop = bc;
    end
    if (rom_re) begin
      chk("rom_addr", rom_addr, exp_addr);
      chk("no_overflow", occ + infl - int'(pop) < 2, 1);
      exp_addr++;
      n_iss++;
    end
    if (done) begin
      n_done++;
      chk("done_busy_low", busy, 0);
    end
    held      = out_valid && !out_ready;
    held_data = out_data;
    held_last = out_last;
    occ       = occ + infl - int'(pop);
    infl      = int'(rom_re);
  endtask

  task automatic run(input int b, input int l, input int m, input int reissue_at);
    logic [DEPTH-1:0] a;
    mode      = m;
    start     = 1'b1;
    base_addr = DEPTH'(b);
    len       = LEN_W'(l);
    for (int k = 0; k < l; k++) begin
      a = DEPTH'(b + k);
      exp_q.push_back({k == l - 1, {4{a}}});
    end
    exp_addr = DEPTH'(b);
    n_iss = 0; n_done = 0; bc = 0; first_v = -1; first_pop = -1; last_pop = -1;
    step();
    chk("busy_on_start", busy, l != 0);
    if (l == 0) chk("zero_len_done", done, 1);
    while (n_done == 0 && bc < 300) begin
      step();
      if (bc == reissue_at) begin
        start     = 1'b1;
        base_addr = 8'h40;
        len       = LEN_W'(3);
      end
    end
    chk("done_seen", n_done, 1);
    chk("all_delivered", exp_q.size(), 0);
    chk("issue_count", n_iss, l);
    chk("buffer_empty", occ + infl, 0);
    step();
    chk("done_pulse_width", done, 0);
    chk("busy_after_done", busy, 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rom_re", rom_re, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = WIDTH'(i) * 32'h01010101;
    #1 rst = 1'b1;
    #2 chk_reset_outputs();
    @(posedge clk); #2 rst = 1'b0;
    step();
    run(8'h10, 4, 0, -1);
    // counted from the edge that accepts start
    chk("first_valid_latency", first_v - 1, RD_LAT + 1);
    chk("back_to_back", last_pop - first_pop, 3);
    run(8'hFE, 4, 0, -1);
    run(8'h00, 6, 1, -1);
    run(8'h00, 0, 0, -1);
    mode = 0;
    start = 1'b1; base_addr = 8'h00; len = LEN_W'(8);
    for (int k = 0; k < 8; k++) exp_q.push_back({k == 7, {4{8'(k)}}});
    exp_addr = '0; bc = 0;
    repeat (4) step();
    rst = 1'b1;
    #1 chk_reset_outputs();
    exp_q.delete();
    occ = 0; infl = 0; held = 1'b0;
    @(posedge clk); #2 rst = 1'b0;
    chk_reset_outputs();
    run(8'h20, 2, 0, -1);
    run(8'h30, 5, 0, 2);
    for (int r = 0; r < 20; r++) run(int'($urandom_range(0, 255)), int'($urandom_range(0, 12)), 2, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
